// File: rtl/tl_pkg.sv
// Shared constants for the byte-stream to TileLink-UL bridge.
// Holds TileLink opcodes, host frame opcodes, response status codes
// and the bridge FSM state type.
package tl_pkg;

  // TileLink-UL opcodes
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // Host command frame opcodes
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Response status bytes
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_DENIED   = 8'hEE;
  localparam logic [7:0] ST_BADOP    = 8'hFF;
  localparam logic [7:0] ST_MISALIGN = 8'hE1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    REQ,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/tilelink_if.sv
// Single-beat TileLink-UL A/D channel bundle.
// master modport: drives the A channel and d_ready.
// slave modport:  drives a_ready and the D channel.
interface tilelink #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_size;
  logic [7:0]        a_source;
  logic [ADDR_W-1:0] a_address;
  logic [7:0]        a_mask;
  logic [DATA_W-1:0] a_data;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic              d_denied;
  logic [DATA_W-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_denied, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_denied, d_data,
    input  d_ready
  );
endinterface

// File: rtl/byte_shreg.sv
// Little-endian byte assembler / serializer.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears q)
//   load        parallel load of load_val (highest priority)
//   load_val    parallel value
//   shift_in    shift byte_in in at the top; after WIDTH/8 shifts the first
//               byte received sits in q[7:0]
//   byte_in     byte to shift in
//   shift_out   drop q[7:0] and move the next byte down
//   q           register contents; q[7:0] is the next byte to serialize
module byte_shreg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_in,
  input  logic [7:0]       byte_in,
  input  logic             shift_out,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_in) begin
      q <= {byte_in, q[WIDTH-1:8]};
    end else if (shift_out) begin
      q <= {8'h00, q[WIDTH-1:8]};
    end
  end

endmodule

// File: rtl/tl_byte_master.sv
// Byte-stream command channel to single-beat TileLink-UL master bridge.
// Pops READ/WRITE frames from a FWFT command FIFO, issues one Get or
// PutFullData at a time, and pushes the status (plus read data) into the
// response FIFO.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_empty/cmd_dout   command FIFO status and head byte (FWFT)
//   cmd_rd_en            pop the command FIFO head
//   res_full             response FIFO full
//   res_wr_en/res_din    push a response byte
//   bus                  TileLink-UL master port
module tl_byte_master
  import tl_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int SOURCE_ID = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_empty,
  input  logic [7:0] cmd_dout,
  output logic       cmd_rd_en,
  input  logic       res_full,
  output logic       res_wr_en,
  output logic [7:0] res_din,
  tilelink.master    bus
);

  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  rem;
  logic        is_write;
  logic        misalign;
  logic        misalign_now;
  logic [7:0]  res_din_r;

  logic        a_valid_r;
  logic [2:0]  a_opcode_r;
  logic [2:0]  a_size_r;
  logic [7:0]  a_mask_r;
  logic [7:0]  a_source_r;

  logic        pop;
  logic        push;
  logic        addr_shift;
  logic        wd_clr;
  logic        wd_shift;
  logic        rd_load;
  logic        rd_shift;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // Gating with rst_n keeps cmd_rd_en low while reset is held even though
  // IDLE would otherwise pop a waiting byte.
  assign pop  = rst_n && !cmd_empty &&
                (state == IDLE || state == ADDR || state == WDATA);
  assign push = (state == RESP) && !res_full;

  assign addr_shift = pop && (state == ADDR);
  // Clearing wdata at every frame start makes a Get carry a_data = 0.
  assign wd_clr     = pop && (state == IDLE);
  assign wd_shift   = pop && (state == WDATA);
  assign rd_load    = (state == WAIT) && bus.d_valid;
  assign rd_shift   = push && (cnt != rem);

  // The lowest address byte arrives first, so alignment is known from it.
  assign misalign_now = (cnt == 8'd0) ? (cmd_dout[2:0] != 3'b000) : misalign;

  byte_shreg #(.WIDTH(ADDR_W)) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .shift_in (addr_shift),
    .byte_in  (cmd_dout),
    .shift_out(1'b0),
    .q        (addr_q)
  );

  byte_shreg #(.WIDTH(DATA_W)) u_wdata (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wd_clr),
    .load_val ('0),
    .shift_in (wd_shift),
    .byte_in  (cmd_dout),
    .shift_out(1'b0),
    .q        (wdata_q)
  );

  byte_shreg #(.WIDTH(DATA_W)) u_rdata (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rd_load),
    .load_val (bus.d_data),
    .shift_in (1'b0),
    .byte_in  (8'h00),
    .shift_out(rd_shift),
    .q        (rdata_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      rem        <= 8'd0;
      is_write   <= 1'b0;
      misalign   <= 1'b0;
      res_din_r  <= 8'h00;
      a_valid_r  <= 1'b0;
      a_opcode_r <= 3'd0;
      a_size_r   <= 3'd0;
      a_mask_r   <= 8'h00;
      a_source_r <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cnt <= 8'd0;
            if (cmd_dout == CMD_READ || cmd_dout == CMD_WRITE) begin
              is_write <= (cmd_dout == CMD_WRITE);
              state    <= ADDR;
            end else begin
              res_din_r <= ST_BADOP;
              rem       <= 8'd0;
              state     <= RESP;
            end
          end
        end

        ADDR: begin
          if (pop) begin
            misalign <= misalign_now;
            if (cnt == 8'(AB - 1)) begin
              cnt <= 8'd0;
              if (misalign_now) begin
                res_din_r <= ST_MISALIGN;
                rem       <= 8'd0;
                state     <= RESP;
              end else if (is_write) begin
                state <= WDATA;
              end else begin
                a_valid_r  <= 1'b1;
                a_opcode_r <= GET;
                a_size_r   <= 3'd3;
                a_mask_r   <= 8'hFF;
                a_source_r <= 8'(SOURCE_ID);
                state      <= REQ;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        WDATA: begin
          if (pop) begin
            if (cnt == 8'(DB - 1)) begin
              cnt        <= 8'd0;
              a_valid_r  <= 1'b1;
              a_opcode_r <= PUT_FULL;
              a_size_r   <= 3'd3;
              a_mask_r   <= 8'hFF;
              a_source_r <= 8'(SOURCE_ID);
              state      <= REQ;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        REQ: begin
          if (bus.a_ready) begin
            a_valid_r <= 1'b0;
            state     <= WAIT;
          end
        end

        WAIT: begin
          if (bus.d_valid) begin
            res_din_r <= bus.d_denied ? ST_DENIED : ST_OK;
            // Only a non-denied AccessAckData carries bytes back to the host.
            rem       <= (!bus.d_denied && bus.d_opcode == ACCESS_ACK_DATA) ?
                         8'(DB) : 8'd0;
            cnt       <= 8'd0;
            state     <= RESP;
          end
        end

        RESP: begin
          // res_din_r only advances on an accepted push, so a stalled byte
          // stays on res_din.
          if (push) begin
            if (cnt == rem) begin
              state <= IDLE;
            end else begin
              res_din_r <= rdata_q[7:0];
              cnt       <= cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_rd_en     = pop;
  assign res_wr_en     = push;
  assign res_din       = res_din_r;

  assign bus.a_valid   = a_valid_r;
  assign bus.a_opcode  = a_opcode_r;
  assign bus.a_size    = a_size_r;
  assign bus.a_mask    = a_mask_r;
  assign bus.a_source  = a_source_r;
  assign bus.a_address = addr_q;
  assign bus.a_data    = wdata_q;
  assign bus.d_ready   = (state == WAIT);

endmodule
